// File: rtl/fiber_pkg.sv
// Shared definitions for the fiber register bus: opcodes, status codes, header
// and response field positions, and the response-header builder.
package fiber_pkg;

  localparam logic [3:0]  OP_READ        = 4'h1;
  localparam logic [3:0]  OP_WRITE       = 4'h2;
  localparam logic [3:0]  RSP_MARK       = 4'h8;

  localparam logic [1:0]  STATUS_OK      = 2'd0;
  localparam logic [1:0]  STATUS_TIMEOUT = 2'd1;
  localparam logic [1:0]  STATUS_BADOP   = 2'd2;

  localparam logic [31:0] READ_ERR_WORD  = 32'hDEADBEEF;

  // Command header layout
  localparam int HDR_OP_HI   = 31;
  localparam int HDR_OP_LO   = 28;
  localparam int HDR_TAG_HI  = 27;
  localparam int HDR_TAG_LO  = 20;
  localparam int HDR_ADDR_HI = 19;
  localparam int HDR_ADDR_LO = 0;

  // Response header layout
  localparam int RSP_MARK_HI   = 31;
  localparam int RSP_MARK_LO   = 28;
  localparam int RSP_STATUS_HI = 27;
  localparam int RSP_STATUS_LO = 26;
  localparam int RSP_TAG_HI    = 25;
  localparam int RSP_TAG_LO    = 20;
  localparam int RSP_ADDR_HI   = 19;
  localparam int RSP_ADDR_LO   = 0;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_DECODE   = 3'd1,
    ST_WDATA    = 3'd2,
    ST_BUS      = 3'd3,
    ST_RSP_HDR  = 3'd4,
    ST_RSP_DATA = 3'd5,
    ST_GAP      = 3'd6
  } fsm_state_e;

  // Only the low six tag bits fit beside the status field.
  function automatic logic [31:0] build_rsp(input logic [1:0]  status,
                                            input logic [5:0]  tag,
                                            input logic [19:0] addr);
    logic [31:0] word;
    word = 32'h0000_0000;
    word[RSP_MARK_HI:RSP_MARK_LO]     = RSP_MARK;
    word[RSP_STATUS_HI:RSP_STATUS_LO] = status;
    word[RSP_TAG_HI:RSP_TAG_LO]       = tag;
    word[RSP_ADDR_HI:RSP_ADDR_LO]     = addr;
    return word;
  endfunction

endpackage

// File: rtl/fiber_bus_timeout.sv
// Bus strobe watchdog: counts cycles the strobe has been high and flags the
// cycle in which the LIMIT-th high cycle is reached.
module fiber_bus_timeout #(
  parameter logic [15:0] LIMIT = 16'd255
) (
  input  logic CLK,
  input  logic RST,
  input  logic clear,
  input  logic start,
  output logic expired
);

  logic [15:0] count_r;

  // Count of strobe-high cycles already completed, saturating at all-ones.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      count_r <= 16'd0;
    end else if (clear) begin
      count_r <= 16'd0;
    end else if (start && (count_r != 16'hFFFF)) begin
      count_r <= count_r + 16'd1;
    end
  end

  assign expired = start && (count_r >= (LIMIT - 16'd1));

endmodule

// File: rtl/fiber_bus_master.sv
// Fiber register bus initiator: pops framed commands from the Aurora RX FIFO,
// runs one bus read/write each and pushes a framed response to the TX FIFO.
module fiber_bus_master
  import fiber_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255,
  parameter int GAP_CYCLES     = 2
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        ENABLE,
  input  logic        CHANNEL_UP,
  input  logic [31:0] CMD_DATA,
  input  logic        CMD_EMPTY,
  output logic        CMD_RD,
  output logic [31:0] RSP_DATA,
  output logic        RSP_WR,
  input  logic        RSP_FULL,
  output logic [31:0] FIBER_BUS_ADDR,
  output logic [31:0] FIBER_BUS_DOUT,
  input  logic [31:0] FIBER_BUS_DIN,
  output logic        FIBER_BUS_WR,
  output logic        FIBER_BUS_RD,
  input  logic        FIBER_BUS_ACK,
  output logic        BUSY,
  output logic [15:0] TIMEOUT_COUNT
);

  localparam logic [15:0] TO_LIMIT = 16'(TIMEOUT_CYCLES);
  localparam logic [15:0] GAP_LAST = 16'(GAP_CYCLES - 1);

  fsm_state_e  state_r;
  logic [31:0] hdr_r;
  logic [31:0] dout_r;
  logic [31:0] rdata_r;
  logic [31:0] rsp_data_r;
  logic [31:0] bus_addr_r;
  logic [1:0]  status_r;
  logic        cmd_rd_r;
  logic        rsp_wr_r;
  logic        bus_rd_r;
  logic        bus_wr_r;
  logic        busy_r;
  logic [15:0] to_count_r;
  logic [15:0] gap_cnt_r;

  logic [3:0]  op_s;
  logic        is_read_s;
  logic        strobe_s;
  logic        clear_s;
  logic        expired_s;
  logic        unused_tag_s;

  assign op_s         = hdr_r[HDR_OP_HI:HDR_OP_LO];
  assign is_read_s    = (op_s == OP_READ);
  assign strobe_s     = bus_rd_r | bus_wr_r;
  assign clear_s      = ~strobe_s;
  assign unused_tag_s = ^hdr_r[HDR_TAG_HI:HDR_TAG_LO + 6];

  fiber_bus_timeout #(
    .LIMIT (TO_LIMIT)
  ) u_timeout (
    .CLK     (CLK),
    .RST     (RST),
    .clear   (clear_s),
    .start   (strobe_s),
    .expired (expired_s)
  );

  // Command/response sequencer; every output is a register.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_r    <= ST_IDLE;
      hdr_r      <= 32'h0;
      dout_r     <= 32'h0;
      rdata_r    <= 32'h0;
      rsp_data_r <= 32'h0;
      bus_addr_r <= 32'h0;
      status_r   <= STATUS_OK;
      cmd_rd_r   <= 1'b0;
      rsp_wr_r   <= 1'b0;
      bus_rd_r   <= 1'b0;
      bus_wr_r   <= 1'b0;
      busy_r     <= 1'b0;
      to_count_r <= 16'd0;
      gap_cnt_r  <= 16'd0;
    end else begin
      cmd_rd_r <= 1'b0;
      rsp_wr_r <= 1'b0;
      // Link loss drops the command silently; GAP still enforces low time.
      if (!CHANNEL_UP && (state_r != ST_IDLE) && (state_r != ST_GAP)) begin
        bus_rd_r  <= 1'b0;
        bus_wr_r  <= 1'b0;
        gap_cnt_r <= 16'd0;
        state_r   <= ST_GAP;
      end else begin
        case (state_r)
          ST_IDLE: begin
            if (ENABLE && CHANNEL_UP && !CMD_EMPTY) begin
              cmd_rd_r <= 1'b1;
              hdr_r    <= CMD_DATA;
              busy_r   <= 1'b1;
              state_r  <= ST_DECODE;
            end
          end
          ST_DECODE: begin
            if (op_s == OP_READ) begin
              bus_addr_r <= {12'h000, hdr_r[HDR_ADDR_HI:HDR_ADDR_LO]};
              state_r    <= ST_BUS;
            end else if (op_s == OP_WRITE) begin
              bus_addr_r <= {12'h000, hdr_r[HDR_ADDR_HI:HDR_ADDR_LO]};
              state_r    <= ST_WDATA;
            end else begin
              status_r <= STATUS_BADOP;
              state_r  <= ST_RSP_HDR;
            end
          end
          ST_WDATA: begin
            if (!CMD_EMPTY) begin
              cmd_rd_r <= 1'b1;
              dout_r   <= CMD_DATA;
              state_r  <= ST_BUS;
            end
          end
          ST_BUS: begin
            // First BUS cycle only presents ADDR/DOUT; the strobe rises after it.
            if (!strobe_s) begin
              bus_rd_r <= is_read_s;
              bus_wr_r <= ~is_read_s;
            end else if (FIBER_BUS_ACK) begin
              rdata_r  <= FIBER_BUS_DIN;
              bus_rd_r <= 1'b0;
              bus_wr_r <= 1'b0;
              status_r <= STATUS_OK;
              state_r  <= ST_RSP_HDR;
            end else if (expired_s) begin
              rdata_r  <= READ_ERR_WORD;
              bus_rd_r <= 1'b0;
              bus_wr_r <= 1'b0;
              status_r <= STATUS_TIMEOUT;
              if (to_count_r != 16'hFFFF) begin
                to_count_r <= to_count_r + 16'd1;
              end
              state_r  <= ST_RSP_HDR;
            end
          end
          ST_RSP_HDR: begin
            if (!RSP_FULL) begin
              rsp_wr_r   <= 1'b1;
              rsp_data_r <= build_rsp(status_r, hdr_r[HDR_TAG_LO + 5:HDR_TAG_LO],
                                      hdr_r[HDR_ADDR_HI:HDR_ADDR_LO]);
              if (is_read_s) begin
                state_r <= ST_RSP_DATA;
              end else begin
                gap_cnt_r <= 16'd0;
                state_r   <= ST_GAP;
              end
            end
          end
          ST_RSP_DATA: begin
            // Skip a cycle after the header push so RSP_FULL reflects it.
            if (!RSP_FULL && !rsp_wr_r) begin
              rsp_wr_r   <= 1'b1;
              rsp_data_r <= rdata_r;
              gap_cnt_r  <= 16'd0;
              state_r    <= ST_GAP;
            end
          end
          ST_GAP: begin
            if (gap_cnt_r >= GAP_LAST) begin
              busy_r  <= 1'b0;
              state_r <= ST_IDLE;
            end else begin
              gap_cnt_r <= gap_cnt_r + 16'd1;
            end
          end
          default: begin
            bus_rd_r <= 1'b0;
            bus_wr_r <= 1'b0;
            busy_r   <= 1'b0;
            state_r  <= ST_IDLE;
          end
        endcase
      end
    end
  end

  assign CMD_RD         = cmd_rd_r;
  assign RSP_WR         = rsp_wr_r;
  assign RSP_DATA       = rsp_data_r;
  assign FIBER_BUS_ADDR = bus_addr_r;
  assign FIBER_BUS_DOUT = dout_r;
  assign FIBER_BUS_RD   = bus_rd_r;
  assign FIBER_BUS_WR   = bus_wr_r;
  assign BUSY           = busy_r;
  assign TIMEOUT_COUNT  = to_count_r;

endmodule

// File: tb/tb_fiber_bus_master.sv
// Directed bench for fiber_bus_master with a FIFO model on each side and a
// responder that acknowledges two cycles after a strobe rises.
module tb_fiber_bus_master;

  logic        CLK = 1'b0;
  logic        RST;
  logic        ENABLE;
  logic        CHANNEL_UP;
  logic [31:0] CMD_DATA;
  logic        CMD_EMPTY;
  logic        CMD_RD;
  logic [31:0] RSP_DATA;
  logic        RSP_WR;
  logic        RSP_FULL;
  logic [31:0] FIBER_BUS_ADDR;
  logic [31:0] FIBER_BUS_DOUT;
  logic [31:0] FIBER_BUS_DIN = 32'h0;
  logic        FIBER_BUS_WR;
  logic        FIBER_BUS_RD;
  logic        FIBER_BUS_ACK = 1'b0;
  logic        BUSY;
  logic [15:0] TIMEOUT_COUNT;

  int checks = 0;
  int errors = 0;

  logic [31:0] cmd_mem [16];
  int          cmd_wp = 0;
  int          cmd_rp = 0;
  logic [31:0] rsp_mem [64];
  int          rsp_cyc [64];
  int          rsp_cnt = 0;

  bit          resp_en = 1'b1;
  logic [31:0] rdata_val = 32'h0;
  int cyc = 0, hi_cnt = 0;
  int rd_rises = 0, wr_rises = 0, rd_len = 0, last_rd_len = 0;
  int rd_rise_cyc = 0, cmd_rd_cyc = 0, cmd_rd_cnt = 0;
  int both_high = 0, overlap = 0, push_full = 0, pop_empty = 0;
  logic        prev_rd = 1'b0;
  logic        prev_wr = 1'b0;
  logic [31:0] ack_dout = 32'h0;
  logic [31:0] ack_addr = 32'h0;

  assign CMD_DATA  = cmd_mem[cmd_rp % 16];
  assign CMD_EMPTY = (cmd_wp == cmd_rp);

  fiber_bus_master #(
    .TIMEOUT_CYCLES (16),
    .GAP_CYCLES     (2)
  ) dut (
    .CLK            (CLK),
    .RST            (RST),
    .ENABLE         (ENABLE),
    .CHANNEL_UP     (CHANNEL_UP),
    .CMD_DATA       (CMD_DATA),
    .CMD_EMPTY      (CMD_EMPTY),
    .CMD_RD         (CMD_RD),
    .RSP_DATA       (RSP_DATA),
    .RSP_WR         (RSP_WR),
    .RSP_FULL       (RSP_FULL),
    .FIBER_BUS_ADDR (FIBER_BUS_ADDR),
    .FIBER_BUS_DOUT (FIBER_BUS_DOUT),
    .FIBER_BUS_DIN  (FIBER_BUS_DIN),
    .FIBER_BUS_WR   (FIBER_BUS_WR),
    .FIBER_BUS_RD   (FIBER_BUS_RD),
    .FIBER_BUS_ACK  (FIBER_BUS_ACK),
    .BUSY           (BUSY),
    .TIMEOUT_COUNT  (TIMEOUT_COUNT)
  );

  always #5 CLK = ~CLK;

  // Responder, FIFO models and protocol monitors, all on the falling edge.
  always @(negedge CLK) begin
    cyc = cyc + 1;
    if (FIBER_BUS_RD && !prev_rd) begin
      rd_rises    = rd_rises + 1;
      rd_rise_cyc = cyc;
    end
    if (FIBER_BUS_WR && !prev_wr) wr_rises = wr_rises + 1;
    if (FIBER_BUS_RD) rd_len = rd_len + 1;
    else if (prev_rd) begin
      last_rd_len = rd_len;
      rd_len      = 0;
    end
    if (FIBER_BUS_RD && FIBER_BUS_WR) both_high = both_high + 1;
    if (CMD_RD && RSP_WR) overlap = overlap + 1;
    if (FIBER_BUS_RD || FIBER_BUS_WR) hi_cnt = hi_cnt + 1;
    else hi_cnt = 0;
    FIBER_BUS_ACK = resp_en && (hi_cnt == 2);
    if (FIBER_BUS_ACK) begin
      FIBER_BUS_DIN = rdata_val;
      ack_dout      = FIBER_BUS_DOUT;
      ack_addr      = FIBER_BUS_ADDR;
    end
    if (RSP_WR) begin
      if (RSP_FULL) push_full = push_full + 1;
      rsp_mem[rsp_cnt % 64] = RSP_DATA;
      rsp_cyc[rsp_cnt % 64] = cyc;
      rsp_cnt = rsp_cnt + 1;
    end
    if (CMD_RD) begin
      if (CMD_EMPTY) pop_empty = pop_empty + 1;
      else cmd_rp = cmd_rp + 1;
      cmd_rd_cyc = cyc;
      cmd_rd_cnt = cmd_rd_cnt + 1;
    end
    prev_rd = FIBER_BUS_RD;
    prev_wr = FIBER_BUS_WR;
  end

  task automatic push_cmd(input logic [31:0] w);
    cmd_mem[cmd_wp % 16] = w;
    cmd_wp = cmd_wp + 1;
  endtask

  task automatic wait_done(input int target, input int max_cyc, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < max_cyc; i++) begin
      @(negedge CLK);
      if ((rsp_cnt >= target) && !BUSY) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic wait_rd_high(input int max_cyc, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < max_cyc; i++) begin
      @(negedge CLK);
      if (FIBER_BUS_RD) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset;
    RST = 1'b1;
    repeat (3) @(negedge CLK);
    checks++;
    if ({CMD_RD, RSP_WR, FIBER_BUS_RD, FIBER_BUS_WR, BUSY, RSP_DATA, FIBER_BUS_ADDR,
         FIBER_BUS_DOUT, TIMEOUT_COUNT} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got addr=%h dout=%h rsp=%h busy=%b tocnt=%0d, want all 0",
               FIBER_BUS_ADDR, FIBER_BUS_DOUT, RSP_DATA, BUSY, TIMEOUT_COUNT);
    end
    RST = 1'b0;
    @(negedge CLK);
  endtask

  task automatic test_read;
    int base, r0;
    bit ok;
    base = rsp_cnt; r0 = rd_rises; rdata_val = 32'h12345678; resp_en = 1'b1;
    push_cmd(32'h12A00100);
    wait_done(base + 2, 100, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL read_done: timed out, want 2 response words"); end
    checks++;
    if (rd_rises - r0 !== 1 || last_rd_len !== 2) begin
      errors++;
      $display("FAIL read_strobe: pulses=%0d len=%0d, want 1 pulse of 2 cycles", rd_rises - r0, last_rd_len);
    end
    checks++;
    if (rd_rise_cyc - cmd_rd_cyc !== 2) begin
      errors++;
      $display("FAIL read_latency: pop to RD=%0d cycles, want 2", rd_rise_cyc - cmd_rd_cyc);
    end
    checks++;
    if (ack_addr !== 32'h00000100) begin
      errors++; $display("FAIL read_addr: got %h want 00000100", ack_addr);
    end
    checks++;
    if (rsp_cnt - base !== 2 || rsp_mem[base % 64] !== 32'h82A00100 || rsp_mem[(base + 1) % 64] !== 32'h12345678) begin
      errors++;
      $display("FAIL read_rsp: n=%0d hdr=%h data=%h, want 2 words 82A00100 12345678",
               rsp_cnt - base, rsp_mem[base % 64], rsp_mem[(base + 1) % 64]);
    end
  endtask

  task automatic test_write;
    int base, r0, w0;
    bit ok;
    base = rsp_cnt; r0 = rd_rises; w0 = wr_rises;
    push_cmd(32'h20500040);
    push_cmd(32'hCAFEF00D);
    wait_done(base + 1, 100, ok);
    repeat (4) @(negedge CLK);
    checks++;
    if (!ok || wr_rises - w0 !== 1 || rd_rises !== r0) begin
      errors++;
      $display("FAIL write_strobe: done=%0b wr=%0d rd=%0d, want 1 WR pulse and no RD", ok, wr_rises - w0, rd_rises - r0);
    end
    checks++;
    if (ack_dout !== 32'hCAFEF00D || ack_addr !== 32'h00000040) begin
      errors++; $display("FAIL write_bus: dout=%h addr=%h want CAFEF00D 00000040", ack_dout, ack_addr);
    end
    checks++;
    if (rsp_cnt - base !== 1 || rsp_mem[base % 64] !== 32'h80500040) begin
      errors++; $display("FAIL write_rsp: n=%0d hdr=%h want 1 word 80500040", rsp_cnt - base, rsp_mem[base % 64]);
    end
  endtask

  task automatic test_timeout;
    int base;
    bit ok;
    base = rsp_cnt; resp_en = 1'b0;
    push_cmd(32'h13C00200);
    wait_done(base + 2, 200, ok);
    checks++;
    if (!ok || last_rd_len !== 16) begin
      errors++; $display("FAIL timeout_len: done=%0b RD high %0d cycles, want 16", ok, last_rd_len);
    end
    checks++;
    if (rsp_mem[base % 64] !== 32'h87C00200 || rsp_mem[(base + 1) % 64] !== 32'hDEADBEEF) begin
      errors++;
      $display("FAIL timeout_rsp: hdr=%h data=%h want 87C00200 DEADBEEF", rsp_mem[base % 64], rsp_mem[(base + 1) % 64]);
    end
    checks++;
    if (TIMEOUT_COUNT !== 16'd1) begin
      errors++; $display("FAIL timeout_count: got %0d want 1", TIMEOUT_COUNT);
    end
    resp_en = 1'b1;
  endtask

  task automatic test_bad_op;
    int base, r0, w0;
    bit ok;
    base = rsp_cnt; rdata_val = 32'h0BADF00D;
    push_cmd(32'h71100ABC);
    push_cmd(32'h10700008);
    r0 = rd_rises; w0 = wr_rises;
    wait_done(base + 3, 200, ok);
    checks++;
    if (!ok || rsp_mem[base % 64] !== 32'h89100ABC) begin
      errors++; $display("FAIL badop_rsp: done=%0b hdr=%h want 89100ABC", ok, rsp_mem[base % 64]);
    end
    checks++;
    if (rd_rises - r0 !== 1 || wr_rises !== w0) begin
      errors++; $display("FAIL badop_strobe: rd=%0d wr=%0d want only the following read", rd_rises - r0, wr_rises - w0);
    end
    checks++;
    if (cmd_rd_cyc - rsp_cyc[base % 64] !== 3) begin
      errors++; $display("FAIL badop_gap: rsp to next pop %0d cycles, want 3", cmd_rd_cyc - rsp_cyc[base % 64]);
    end
    checks++;
    if (rsp_mem[(base + 1) % 64] !== 32'h80700008 || rsp_mem[(base + 2) % 64] !== 32'h0BADF00D) begin
      errors++;
      $display("FAIL badop_next: hdr=%h data=%h want 80700008 0BADF00D", rsp_mem[(base + 1) % 64], rsp_mem[(base + 2) % 64]);
    end
  endtask

  task automatic test_rsp_stall;
    int base, c0, n0;
    bit ok;
    base = rsp_cnt; rdata_val = 32'hA5A50001; RSP_FULL = 1'b1;
    push_cmd(32'h10100010);
    push_cmd(32'h20200020);
    push_cmd(32'h11112222);
    repeat (10) @(negedge CLK);
    c0 = cmd_rd_cnt; n0 = rsp_cnt;
    repeat (50) @(negedge CLK);
    checks++;
    if (cmd_rd_cnt !== c0 || rsp_cnt !== n0 || rsp_cnt !== base || !BUSY) begin
      errors++;
      $display("FAIL stall_hold: pops=%0d pushes=%0d busy=%b, want 0 0 1", cmd_rd_cnt - c0, rsp_cnt - base, BUSY);
    end
    RSP_FULL = 1'b0;
    wait_done(base + 3, 200, ok);
    checks++;
    if (!ok || rsp_mem[base % 64] !== 32'h80100010 || rsp_mem[(base + 1) % 64] !== 32'hA5A50001 ||
        rsp_mem[(base + 2) % 64] !== 32'h80200020) begin
      errors++;
      $display("FAIL stall_order: done=%0b %h %h %h want 80100010 A5A50001 80200020", ok,
               rsp_mem[base % 64], rsp_mem[(base + 1) % 64], rsp_mem[(base + 2) % 64]);
    end
  endtask

  task automatic test_enable;
    int base, c0;
    bit ok;
    base = rsp_cnt; c0 = cmd_rd_cnt; ENABLE = 1'b0;
    push_cmd(32'h20F00050);
    push_cmd(32'h0000BEEF);
    repeat (6) @(negedge CLK);
    checks++;
    if (BUSY || cmd_rd_cnt !== c0) begin
      errors++; $display("FAIL enable_block: busy=%b pops=%0d want 0 0", BUSY, cmd_rd_cnt - c0);
    end
    ENABLE = 1'b1;
    wait_done(base + 1, 100, ok);
    checks++;
    if (!ok || rsp_mem[base % 64] !== 32'h80F00050 || ack_dout !== 32'h0000BEEF) begin
      errors++; $display("FAIL enable_run: done=%0b hdr=%h dout=%h want 80F00050 0000BEEF", ok, rsp_mem[base % 64], ack_dout);
    end
  endtask

  task automatic test_channel_drop;
    int base;
    bit ok;
    base = rsp_cnt; resp_en = 1'b0;
    push_cmd(32'h13300300);
    wait_rd_high(20, ok);
    CHANNEL_UP = 1'b0;
    @(negedge CLK);
    checks++;
    if (!ok || FIBER_BUS_RD !== 1'b0) begin
      errors++; $display("FAIL chan_drop_rd: reached=%0b RD=%b, want RD low next cycle", ok, FIBER_BUS_RD);
    end
    repeat (5) @(negedge CLK);
    checks++;
    if (rsp_cnt !== base || BUSY !== 1'b0 || TIMEOUT_COUNT !== 16'd1) begin
      errors++;
      $display("FAIL chan_drop_rsp: pushes=%0d busy=%b tocnt=%0d want 0 0 1", rsp_cnt - base, BUSY, TIMEOUT_COUNT);
    end
    CHANNEL_UP = 1'b1;
    resp_en = 1'b1;
  endtask

  task automatic test_reset_mid_bus;
    bit ok;
    resp_en = 1'b0;
    push_cmd(32'h14400400);
    wait_rd_high(20, ok);
    #2 RST = 1'b1;
    #1;
    checks++;
    if (!ok || {FIBER_BUS_RD, FIBER_BUS_WR, BUSY, RSP_WR, CMD_RD} !== 5'b00000 ||
        FIBER_BUS_ADDR !== 32'h0 || TIMEOUT_COUNT !== 16'd0) begin
      errors++;
      $display("FAIL reset_mid_bus: reached=%0b RD=%b busy=%b addr=%h tocnt=%0d want all 0",
               ok, FIBER_BUS_RD, BUSY, FIBER_BUS_ADDR, TIMEOUT_COUNT);
    end
    @(negedge CLK);
    RST = 1'b0;
    resp_en = 1'b1;
    repeat (2) @(negedge CLK);
  endtask

  task automatic test_invariants;
    checks++;
    if (both_high !== 0 || overlap !== 0) begin
      errors++; $display("FAIL exclusive_strobes: rd&wr=%0d cmd_rd&rsp_wr=%0d want 0 0", both_high, overlap);
    end
    checks++;
    if (push_full !== 0 || pop_empty !== 0) begin
      errors++; $display("FAIL fifo_rules: push_full=%0d pop_empty=%0d want 0 0", push_full, pop_empty);
    end
  endtask

  initial begin
    RST = 1'b1; ENABLE = 1'b1; CHANNEL_UP = 1'b1; RSP_FULL = 1'b0;
    test_reset;
    test_read;
    test_write;
    test_timeout;
    test_bad_op;
    test_rsp_stall;
    test_enable;
    test_channel_drop;
    test_reset_mid_bus;
    test_invariants;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1);
  end

endmodule
